text_cell_renderer: RTL and testbench
=====================================

Name: text_cell_renderer

Overview:
- Parametrised text-mode pixel generator for the gfx pipeline. Sits between the character/attribute buffer reader and the video timing/output stage.
- Fetches one glyph row per character cell from an external synchronous font ROM (1-cycle latency) and double-buffers it so the next cell is prefetched while the current cell is shifted out.
- Produces a COLOR_BITS-wide colour per pixel, with per-cell fg/bg attributes, attribute blink, a blinking block cursor and underrun detection.

Parameters:
- COL_WIDTH, 8: glyph width in pixels; must be >= 4.
- ROW_HEIGHT, 16: glyph height in rows; a power of 2.
- COLOR_BITS, 4: width of each of fg, bg and pix_color.
- BLINK_LOG2, 5: blink phase = bit BLINK_LOG2-1 of the frame counter (32-frame period at default).
- CURSOR_START, 14: first glyph row of the cursor block. Cursor spans rows CURSOR_START..ROW_HEIGHT-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  0 forces pix_color to 0; pipeline keeps running
- frame_start  in  1  one-cycle pulse per frame; advances blink counter
- line_start  in  1  one-cycle pulse before the first pixel of a scanline
- glyph_y  in  $clog2(ROW_HEIGHT)  glyph row for the current scanline; stable for the whole line
- pix_en  in  1  pixel advance strobe
- next_char  in  8  character code of the cell to fetch
- next_attr  in  2*COLOR_BITS+1  [C-1:0]=fg, [2C-1:C]=bg, [2C]=blink, where C=COLOR_BITS
- next_cursor  in  1  cell to fetch holds the cursor
- cell_ack  out  1  pulse: next_* sampled this cycle; upstream must advance to the following cell
- rom_addr  out  8+$clog2(ROW_HEIGHT)  {char, glyph_y}, registered
- rom_data  in  COL_WIDTH  glyph row, valid the cycle after rom_addr; MSB is the leftmost pixel
- pix_color  out  COLOR_BITS  registered pixel colour
- pix_valid  out  1  pix_color updated this cycle
- underrun  out  1  sticky: cell boundary reached with no glyph staged

Behaviour:
- Reset values:
  - all outputs 0; rom_addr 0
  - col, shift register, staging, staged_valid, fetch state and frame counter all 0
- Fetch FSM, states IDLE -> ADDR -> DATA -> IDLE:
  - Launch in cycle T: sample next_*; pulse cell_ack in T; register rom_addr = {next_char, glyph_y} (valid T+1).
  - ADDR (T+1): ROM access.
  - DATA (T+2): capture rom_data, attr and cursor into staging; staged_valid <= 1.
  - Launch triggers: line_start, and every pix_en that loads the shift register.
- line_start:
  - col <= 0; clear staged_valid and underrun.
  - Abort any fetch in flight and relaunch immediately; the aborted fetch never sets staged_valid.
  - pix_en must not occur before staged_valid is 1 (bench rule).
- pix_en with col == 0 and staged_valid == 1:
  - Shift register <= staging; active attr/cursor <= staged copy; staged_valid <= 0.
  - Launch the next fetch in the same cycle.
  - The pixel output is the MSB of the staging word.
- pix_en with col != 0: output the shift register MSB, then shift left by 1.
- col counter:
  - increments on every pix_en; wraps COL_WIDTH-1 -> 0
  - COL_WIDTH >= 4 plus pix_en spacing >= 1 cycle guarantees the prefetch lands before the next boundary.
- Underrun: pix_en at col 0 with staged_valid == 0:
  - pix_color <= 0; underrun <= 1 (sticky).
  - col still advances; no fetch is launched; the shift register is cleared.
- Colour, computed per pixel with p = glyph bit and phase = frame_cnt[BLINK_LOG2-1]:
  - fg_eff = (blink && phase) ? bg : fg
  - base = p ? fg_eff : bg
  - If cursor && glyph_y >= CURSOR_START && !phase: base = p ? bg : fg (inverted block).
  - pix_color <= enable ? base : 0.
- Output timing: pix_valid <= pix_en; latency pix_en -> pix_color is exactly 1 cycle.
- frame_start: frame_cnt <= frame_cnt + 1, BLINK_LOG2 bits wide, wraps to 0.
- Simultaneous events:
  - line_start together with pix_en: line_start wins and pix_en is ignored.
  - frame_start together with any other event: the counter updates, and the new phase applies from the next pixel.
- Reset mid-line: all state clears asynchronously; nothing resumes until the next line_start.

Test Plan:
- Reset asserted mid-fetch -> all outputs 0 immediately; after release, pix_en with no line_start gives pix_color=0 and underrun=1.
- line_start, next_char=0x41, glyph_y=3 -> cell_ack in T, rom_addr=0x413 in T+1; ROM returns 0xA5 with attr fg=0xF, bg=0x1; 8 pix_en -> colours F,1,F,1,1,F,1,F, each 1 cycle after its pix_en.
- 4 consecutive cells with pix_en every 2 cycles -> cell_ack once per cell, no underrun, pixel stream continuous across boundaries.
- Blink attr set with fg=0xC, bg=0x2 -> after 16 frame_start pulses (phase=1) every pixel is 0x2; after 32 pulses the glyph reappears.
- Cursor cell, glyph_y=15, phase 0, rom_data=0x00 -> all 8 pixels = fg; glyph_y=13 -> all 8 pixels = bg.
- Withhold the ROM response at a boundary (line_start mid-line aborts the fetch) -> aborted data is never shown; underrun clears on line_start; enable=0 -> pix_color=0 while pix_valid still pulses.

Source files
------------

// File: rtl/text_cell_renderer.sv
// Text-mode cell renderer: prefetches one glyph row per character cell from a synchronous
// font ROM and shifts it out as per-pixel colours with blink, block cursor and underrun flag.
module text_cell_renderer #(
   parameter int COL_WIDTH    = 8,
   parameter int ROW_HEIGHT   = 16,
   parameter int COLOR_BITS   = 4,
   parameter int BLINK_LOG2   = 5,
   parameter int CURSOR_START = 14
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            enable,
   input  logic                            frame_start,
   input  logic                            line_start,
   input  logic [$clog2(ROW_HEIGHT)-1:0]   glyph_y,
   input  logic                            pix_en,
   input  logic [7:0]                      next_char,
   input  logic [2*COLOR_BITS:0]           next_attr,
   input  logic                            next_cursor,
   output logic                            cell_ack,
   output logic [8+$clog2(ROW_HEIGHT)-1:0] rom_addr,
   input  logic [COL_WIDTH-1:0]            rom_data,
   output logic [COLOR_BITS-1:0]           pix_color,
   output logic                            pix_valid,
   output logic                            underrun
);
   localparam int YW = $clog2(ROW_HEIGHT);
   localparam int CW = $clog2(COL_WIDTH);
   localparam int AW = 2*COLOR_BITS+1;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [8+YW-1:0]       rom_addr_q, rom_addr_d;
   logic [AW-1:0]         fetch_attr_q, fetch_attr_d;
   logic                  fetch_cursor_q, fetch_cursor_d;
   logic [COL_WIDTH-1:0]  staging_q, staging_d;
   logic [AW-1:0]         staged_attr_q, staged_attr_d;
   logic                  staged_cursor_q, staged_cursor_d;
   logic                  staged_valid_q, staged_valid_d;
   logic [COL_WIDTH-1:0]  shift_q, shift_d;
   logic [AW-1:0]         act_attr_q, act_attr_d;
   logic                  act_cursor_q, act_cursor_d;
   logic [CW-1:0]         col_q, col_d;
   logic [BLINK_LOG2-1:0] frame_cnt_q, frame_cnt_d;
   logic [COLOR_BITS-1:0] pix_color_q, pix_color_d;
   logic                  pix_valid_q, pix_valid_d;
   logic                  underrun_q, underrun_d;

   logic                  pix_go, load, launch, pix_bit, cur_sel, blank_px, phase, cursor_row;
   logic [AW-1:0]         attr_sel;

   function automatic logic [COLOR_BITS-1:0] cell_color(
      input logic          p,
      input logic [AW-1:0] attr,
      input logic          cursor,
      input logic          blink_phase,
      input logic          on_cursor_row
   );
      logic [COLOR_BITS-1:0] fg, bg, fg_eff;
      fg     = attr[COLOR_BITS-1:0];
      bg     = attr[2*COLOR_BITS-1:COLOR_BITS];
      fg_eff = (attr[2*COLOR_BITS] && blink_phase) ? bg : fg;
      // Cursor block is an inverted cell, shown only during the visible blink half
      if (cursor && on_cursor_row && !blink_phase) cell_color = p ? bg : fg;
      else                                          cell_color = p ? fg_eff : bg;
   endfunction

   assign pix_go     = pix_en && !line_start;
   assign load       = pix_go && (col_q == '0) && staged_valid_q;
   assign launch     = line_start || load;
   assign phase      = frame_cnt_q[BLINK_LOG2-1];
   assign cursor_row = int'(glyph_y) >= CURSOR_START;

   always_comb begin
      state_d         = state_q;
      rom_addr_d      = rom_addr_q;
      fetch_attr_d    = fetch_attr_q;
      fetch_cursor_d  = fetch_cursor_q;
      staging_d       = staging_q;
      staged_attr_d   = staged_attr_q;
      staged_cursor_d = staged_cursor_q;
      staged_valid_d  = staged_valid_q;
      shift_d         = shift_q;
      act_attr_d      = act_attr_q;
      act_cursor_d    = act_cursor_q;
      col_d           = col_q;
      underrun_d      = underrun_q;
      pix_color_d     = pix_color_q;
      pix_valid_d     = pix_go;
      frame_cnt_d     = frame_start ? frame_cnt_q + BLINK_LOG2'(1) : frame_cnt_q;
      pix_bit         = shift_q[COL_WIDTH-1];
      attr_sel        = act_attr_q;
      cur_sel         = act_cursor_q;
      blank_px        = 1'b0;

      // A launch (including a line_start abort) overrides whatever fetch is in flight
      if (launch) begin
         state_d        = S_ADDR;
         rom_addr_d     = {next_char, glyph_y};
         fetch_attr_d   = next_attr;
         fetch_cursor_d = next_cursor;
      end else begin
         case (state_q)
            S_ADDR:  state_d = S_DATA;
            S_DATA: begin
               state_d         = S_IDLE;
               staging_d       = rom_data;
               staged_attr_d   = fetch_attr_q;
               staged_cursor_d = fetch_cursor_q;
               staged_valid_d  = 1'b1;
            end
            default: state_d = S_IDLE;
         endcase
      end

      if (line_start) begin
         col_d          = '0;
         staged_valid_d = 1'b0;
         underrun_d     = 1'b0;
      end else if (pix_go) begin
         col_d = (col_q == CW'(COL_WIDTH-1)) ? '0 : col_q + CW'(1);
         if (col_q != '0) begin
            shift_d = shift_q << 1;
         end else if (staged_valid_q) begin
            pix_bit        = staging_q[COL_WIDTH-1];
            attr_sel       = staged_attr_q;
            cur_sel        = staged_cursor_q;
            shift_d        = staging_q << 1;
            act_attr_d     = staged_attr_q;
            act_cursor_d   = staged_cursor_q;
            staged_valid_d = 1'b0;
         end else begin
            shift_d    = '0;
            underrun_d = 1'b1;
            blank_px   = 1'b1;
         end
         pix_color_d = (enable && !blank_px) ?
                       cell_color(pix_bit, attr_sel, cur_sel, phase, cursor_row) : '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= S_IDLE;
         rom_addr_q      <= '0;
         fetch_attr_q    <= '0;
         fetch_cursor_q  <= 1'b0;
         staging_q       <= '0;
         staged_attr_q   <= '0;
         staged_cursor_q <= 1'b0;
         staged_valid_q  <= 1'b0;
         shift_q         <= '0;
         act_attr_q      <= '0;
         act_cursor_q    <= 1'b0;
         col_q           <= '0;
         frame_cnt_q     <= '0;
         pix_color_q     <= '0;
         pix_valid_q     <= 1'b0;
         underrun_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         rom_addr_q      <= rom_addr_d;
         fetch_attr_q    <= fetch_attr_d;
         fetch_cursor_q  <= fetch_cursor_d;
         staging_q       <= staging_d;
         staged_attr_q   <= staged_attr_d;
         staged_cursor_q <= staged_cursor_d;
         staged_valid_q  <= staged_valid_d;
         shift_q         <= shift_d;
         act_attr_q      <= act_attr_d;
         act_cursor_q    <= act_cursor_d;
         col_q           <= col_d;
         frame_cnt_q     <= frame_cnt_d;
         pix_color_q     <= pix_color_d;
         pix_valid_q     <= pix_valid_d;
         underrun_q      <= underrun_d;
      end
   end

   assign cell_ack  = launch;
   assign rom_addr  = rom_addr_q;
   assign pix_color = pix_color_q;
   assign pix_valid = pix_valid_q;
   assign underrun  = underrun_q;

endmodule

// File: tb/tb_text_cell_renderer.sv
// Bench for text_cell_renderer: font ROM model, upstream cell feeder, table vectors and
// a behavioural pixel model feeding a scoreboard queue.
module tb_text_cell_renderer;
   logic        clk, reset, enable, frame_start, line_start, pix_en, next_cursor;
   logic [3:0]  glyph_y;
   logic [7:0]  next_char;
   logic [8:0]  next_attr;
   logic        cell_ack, pix_valid, underrun;
   logic [11:0] rom_addr;
   logic [7:0]  rom_data;
   logic [3:0]  pix_color;

   text_cell_renderer dut (
      .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
      .line_start(line_start), .glyph_y(glyph_y), .pix_en(pix_en),
      .next_char(next_char), .next_attr(next_attr), .next_cursor(next_cursor),
      .cell_ack(cell_ack), .rom_addr(rom_addr), .rom_data(rom_data),
      .pix_color(pix_color), .pix_valid(pix_valid), .underrun(underrun)
   );

   typedef struct { logic [7:0] ch; logic [8:0] attr; logic cur; } cell_t;
   typedef struct { logic [7:0] ch; logic [3:0] gy; logic [8:0] attr; logic cur; logic en; logic [31:0] exp; } vec_t;

   cell_t      cells [256];
   cell_t      line_cells [64];
   int         ack_cyc [64];
   logic [3:0] exp_q [$];
   int         n_cmp = 0, n_bad = 0;
   int         ack_cnt = 0, line_n = 0, use_idx = 0, pix_n = 0, cyc = 0;
   logic [7:0] act_glyph;
   logic [8:0] act_attr;
   logic       act_cur, m_under, table_mode;
   logic [4:0] fcnt;
   logic [31:0] tbl_exp;
   vec_t       vt [7];

   function automatic logic [7:0] rom_fn(input logic [11:0] a);
      if (a[11:4] == 8'h00) return 8'h00;
      if (a == 12'h413)     return 8'hA5;
      return a[11:4] ^ {a[3:0], a[3:0]};
   endfunction

   function automatic logic [3:0] exp_color(input logic p, input logic [8:0] attr, input logic cur,
                                            input logic ph, input logic [3:0] gy, input logic en);
      if (!en) return 4'h0;
      if (cur && gy >= 4'd14 && !ph) return p ? attr[7:4] : attr[3:0];
      if (!p) return attr[7:4];
      return (attr[8] && ph) ? attr[7:4] : attr[3:0];
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom_fn(rom_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic mon_tick();
      logic [3:0] e;
      int col;
      logic under_px;
      if (reset) begin
         line_n = 0; use_idx = 0; pix_n = 0; m_under = 0; fcnt = '0;
         act_glyph = '0; act_attr = '0; act_cur = 0;
         exp_q.delete();
         return;
      end
      cyc++;
      chk("pix_valid", pix_valid, exp_q.size() != 0);
      if (pix_valid && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("pix_color", pix_color, e);
         chk("underrun_live", underrun, m_under);
      end else if (exp_q.size() != 0) exp_q.delete();
      if (line_start) begin line_n = 0; use_idx = 0; pix_n = 0; m_under = 0; end
      if (cell_ack) begin
         if (line_n < 64) begin
            line_cells[line_n] = cells[ack_cnt];
            ack_cyc[line_n] = cyc;
            line_n++;
         end
         ack_cnt++;
      end
      if (pix_en && !line_start) begin
         col = pix_n % 8;
         under_px = 1'b0;
         if (col == 0) begin
            if (use_idx < line_n && (cyc - ack_cyc[use_idx]) >= 3) begin
               act_glyph = rom_fn({line_cells[use_idx].ch, glyph_y});
               act_attr  = line_cells[use_idx].attr;
               act_cur   = line_cells[use_idx].cur;
               use_idx++;
            end else begin
               act_glyph = '0; m_under = 1'b1; under_px = 1'b1;
            end
         end
         e = under_px ? 4'h0 : exp_color(act_glyph[7-col], act_attr, act_cur, fcnt[4], glyph_y, enable);
         if (table_mode) e = 4'(tbl_exp >> (28 - 4*pix_n));
         exp_q.push_back(e);
         pix_n++;
      end
      if (frame_start) fcnt = fcnt + 5'd1;
   endtask

   task automatic set_next();
      next_char = cells[ack_cnt].ch; next_attr = cells[ack_cnt].attr; next_cursor = cells[ack_cnt].cur;
   endtask

   task automatic step(input logic ls, input logic pe, input logic fs);
      set_next();
      line_start = ls; pix_en = pe; frame_start = fs;
      @(posedge clk); #1;
      line_start = 0; pix_en = 0; frame_start = 0;
   endtask

   task automatic fill(input logic [7:0] ch, input logic [8:0] attr, input logic cur);
      for (int k = 0; k < 8; k++)
         if (ack_cnt + k < 256) cells[ack_cnt + k] = '{ch, attr, cur};
   endtask

   task automatic pixels(input int n);
      for (int k = 0; k < n; k++) begin step(0, 1, 0); step(0, 0, 0); end
   endtask

   task automatic run_line(input int n);
      step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
      pixels(n);
      step(0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run exceeded time limit at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int a0;
      vt[0] = '{8'h41, 4'd3,  9'h01F, 1'b0, 1'b1, 32'hF1F11F1F};
      vt[1] = '{8'h41, 4'd3,  9'h01F, 1'b0, 1'b0, 32'h00000000};
      vt[2] = '{8'h00, 4'd15, 9'h03C, 1'b1, 1'b1, 32'hCCCCCCCC};
      vt[3] = '{8'h00, 4'd13, 9'h03C, 1'b1, 1'b1, 32'h33333333};
      vt[4] = '{8'h41, 4'd15, 9'h03C, 1'b1, 1'b1, 32'h3C33333C};
      vt[5] = '{8'h41, 4'd3,  9'h12C, 1'b0, 1'b1, 32'hC2C22C2C};
      vt[6] = '{8'h41, 4'd15, 9'h03C, 1'b0, 1'b1, 32'hC3CCCCC3};
      for (int k = 0; k < 256; k++) cells[k] = '{8'h00, 9'h000, 1'b0};
      reset = 1; enable = 1; frame_start = 0; line_start = 0; pix_en = 0; glyph_y = 0;
      table_mode = 0; tbl_exp = '0; m_under = 0; fcnt = '0;
      act_glyph = '0; act_attr = '0; act_cur = 0;
      set_next();
      fork
         forever begin @(negedge clk); mon_tick(); end
      join_none
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cell_ack", cell_ack, 0);  chk("rst_rom_addr", rom_addr, 0);
      chk("rst_pix_color", pix_color, 0); chk("rst_pix_valid", pix_valid, 0);
      chk("rst_underrun", underrun, 0);
      @(posedge clk); #1 reset = 0;

      // First cell: ack and ROM address timing, then the pixel stream
      fill(8'h41, 9'h01F, 1'b0); glyph_y = 4'd3;
      set_next(); line_start = 1;
      @(negedge clk); chk("cell_ack_T", cell_ack, 1);
      @(posedge clk); #1 line_start = 0; set_next();
      @(negedge clk); chk("rom_addr_T1", rom_addr, 12'h413); chk("cell_ack_T1", cell_ack, 0);
      @(posedge clk); #1;
      step(0, 0, 0);
      pixels(8); step(0, 0, 0);

      for (int i = 0; i < 7; i++) begin
         fill(vt[i].ch, vt[i].attr, vt[i].cur);
         glyph_y = vt[i].gy; enable = vt[i].en;
         tbl_exp = vt[i].exp; table_mode = 1;
         run_line(8);
         table_mode = 0; enable = 1;
      end

      // Four back-to-back cells with a pixel every second cycle
      glyph_y = 4'd3;
      cells[ack_cnt]   = '{8'h12, 9'h0A7, 1'b0};
      cells[ack_cnt+1] = '{8'h5A, 9'h15E, 1'b1};
      cells[ack_cnt+2] = '{8'h81, 9'h034, 1'b0};
      cells[ack_cnt+3] = '{8'hC3, 9'h0F0, 1'b0};
      cells[ack_cnt+4] = '{8'h07, 9'h019, 1'b0};
      a0 = ack_cnt;
      run_line(32);
      chk("acks_4cells", ack_cnt - a0, 5);
      chk("no_underrun_4cells", underrun, 0);

      // Blink: visible, hidden after 16 frames, visible again after 32
      fill(8'h41, 9'h12C, 1'b0); glyph_y = 4'd3;
      step(1, 1, 0); step(0, 0, 0); step(0, 0, 0);
      pixels(8); step(0, 0, 0);
      repeat (16) step(0, 0, 1);
      fill(8'h41, 9'h12C, 1'b0);
      run_line(8);
      repeat (16) step(0, 0, 1);
      fill(8'h41, 9'h12C, 1'b0);
      run_line(8);

      // Underrun on a premature pixel, cleared by line_start
      fill(8'h5A, 9'h0A7, 1'b0);
      step(1, 0, 0); step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
      @(negedge clk); chk("underrun_set", underrun, 1);
      @(posedge clk); #1;
      step(1, 0, 0);
      @(negedge clk); chk("underrun_cleared", underrun, 0);
      @(posedge clk); #1;
      step(0, 0, 0); pixels(8); step(0, 0, 0);

      // Fetch in flight at a cell boundary is aborted by line_start
      cells[ack_cnt]   = '{8'h5A, 9'h0A7, 1'b0};
      cells[ack_cnt+1] = '{8'h81, 9'h034, 1'b0};
      cells[ack_cnt+2] = '{8'hFF, 9'h0F5, 1'b0};
      for (int k = 3; k < 8; k++) cells[ack_cnt+k] = '{8'h41, 9'h061, 1'b0};
      step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
      pixels(8);
      step(0, 1, 0); step(0, 0, 0);
      step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
      pixels(8); step(0, 0, 0);
      chk("abort_no_underrun", underrun, 0);

      // Asynchronous reset in the middle of a fetch
      fill(8'h41, 9'h01F, 1'b0);
      step(1, 0, 0);
      #2 reset = 1;
      #1;
      chk("arst_cell_ack", cell_ack, 0);  chk("arst_rom_addr", rom_addr, 0);
      chk("arst_pix_color", pix_color, 0); chk("arst_pix_valid", pix_valid, 0);
      chk("arst_underrun", underrun, 0);
      @(posedge clk); @(posedge clk); #1 reset = 0;
      step(0, 1, 0);
      @(negedge clk); chk("post_rst_underrun", underrun, 1); chk("post_rst_color", pix_color, 0);
      @(posedge clk); #1;
      step(0, 0, 0); step(0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
